// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared FSM states, phase constants and transition classifier
package quad_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_REV     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Forward walks 00 -> 10 -> 11 -> 01 -> 00; any other single-bit change is reverse.
  function automatic step_t classify(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    if (prev == cur) begin
      s = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = STEP_ILLEGAL;
    end else begin
      case ({prev, cur})
        {PH_00, PH_10},
        {PH_10, PH_11},
        {PH_11, PH_01},
        {PH_01, PH_00}: s = STEP_FWD;
        default:        s = STEP_REV;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// rtl/quad_sync_filter.sv - one-channel synchroniser followed by a persistence glitch filter
module quad_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (sync_lvl == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        dout  <= sync_lvl;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature front end producing inc/dec step pulses, dir and sticky err
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic qa,
  input  logic qb,
  input  logic clr_err,
  output logic inc,
  output logic dec,
  output logic dir,
  output logic err
);

  localparam int SETTLE = SYNC_STAGES + FILTER_LEN;
  localparam int SW     = $clog2(SETTLE + 1);

  logic          filt_a;
  logic          filt_b;
  logic [1:0]    cur;
  logic [1:0]    prev_q;
  logic [SW-1:0] settle_q;
  state_t        state_q;
  step_t         step;

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .din(qa), .dout(filt_a)
  );

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .din(qb), .dout(filt_b)
  );

  assign cur  = {filt_a, filt_b};
  assign step = classify(prev_q, cur);

  // INIT waits one cycle past the pipeline fill so prev captures the settled position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      settle_q <= '0;
      prev_q   <= PH_00;
      inc      <= 1'b0;
      dec      <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      inc <= 1'b0;
      dec <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (clr_err) err <= 1'b0;
          if (settle_q == SW'(SETTLE)) begin
            prev_q  <= cur;
            state_q <= ST_TRACK;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        ST_TRACK: begin
          prev_q <= cur;
          case (step)
            STEP_FWD: begin
              inc <= 1'b1;
              dir <= 1'b1;
            end
            STEP_REV: begin
              dec <= 1'b1;
              dir <= 1'b0;
            end
            default: ;
          endcase
          if (step == STEP_ILLEGAL) err <= 1'b1;
          else if (clr_err)         err <= 1'b0;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - directed and randomized checks of quad_step_decoder against a history-based model
module tb_quad_step_decoder;

  localparam int S   = 2;
  localparam int FL  = 4;
  localparam int LAT = S + FL + 1;

  logic clk = 1'b0;
  logic rst, qa, qb, clr_err;
  logic inc, dec, dir, err;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_step_decoder #(.SYNC_STAGES(S), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .qa(qa), .qb(qb), .clr_err(clr_err),
    .inc(inc), .dec(dec), .dir(dir), .err(err)
  );

  // Reference: raw samples since reset, filtered level derived from the last FL synchronised samples,
  // step direction from position distance around the 4-state cycle.
  logic       ha[$];
  logic       hb[$];
  int         e;
  int         md;
  logic       mfa, mfb;
  logic [1:0] f1, f2;
  logic       m_inc, m_dec, m_dir, m_err;

  function automatic int pos(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic filt_next(input bit ch, input logic cf);
    int k;
    for (int j = 0; j < FL; j++) begin
      k = e - j;
      if (k - S < 1) return cf;
      if ((ch ? hb[k-S-1] : ha[k-S-1]) == cf) return cf;
    end
    return ~cf;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ha.delete(); hb.delete();
      e = 0; mfa = 0; mfb = 0; f1 = 2'b00; f2 = 2'b00;
      m_inc = 0; m_dec = 0; m_dir = 0; m_err = 0;
    end else begin
      e++;
      ha.push_back(qa);
      hb.push_back(qb);
      md = (pos(f1) - pos(f2) + 4) % 4;
      if (e >= S + FL + 2) begin
        m_inc = (md == 1);
        m_dec = (md == 3);
        if (md == 1) m_dir = 1;
        if (md == 3) m_dir = 0;
        if (md == 2) m_err = 1;
        else if (clr_err) m_err = 0;
      end else begin
        m_inc = 0; m_dec = 0;
        if (clr_err) m_err = 0;
      end
      f2  = f1;
      mfa = filt_next(1'b0, mfa);
      mfb = filt_next(1'b1, mfb);
      f1  = {mfa, mfb};
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({inc, dec, dir, err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=0000", {inc, dec, dir, err});
    end
    rst = 0;
    repeat (20) begin
      @(negedge clk);
      n_chk++;
      if ({inc, dec, dir, err} !== {m_inc, m_dec, m_dir, m_err}) begin
        n_fail++; $display("FAIL settle got=%b want=%b", {inc, dec, dir, err}, {m_inc, m_dec, m_dir, m_err});
      end
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    int npulse = 0;
    int t0;
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    for (int k = 0; k < 4; k++) begin
      {qa, qb} = seq[k];
      t0 = cyc;
      repeat (10) begin
        @(negedge clk);
        n_chk++;
        if ({inc, dec, dir, err} !== {m_inc, m_dec, m_dir, m_err}) begin
          n_fail++; $display("FAIL fwd_model got=%b want=%b", {inc, dec, dir, err}, {m_inc, m_dec, m_dir, m_err});
        end
        if (inc === 1'b1) begin
          npulse++;
          n_chk++;
          if (cyc - t0 != LAT) begin
            n_fail++; $display("FAIL fwd_latency got=%0d want=%0d", cyc - t0, LAT);
          end
        end
        n_chk++;
        if (dec !== 1'b0) begin
          n_fail++; $display("FAIL fwd_no_dec got=%b want=0", dec);
        end
      end
    end
    n_chk++;
    if (npulse != 4) begin
      n_fail++; $display("FAIL fwd_count got=%0d want=4", npulse);
    end
    n_chk++;
    if ({dir, err} !== 2'b10) begin
      n_fail++; $display("FAIL fwd_dir_err got=%b want=10", {dir, err});
    end
  endtask

  task automatic test_reverse();
    logic [1:0] seq [4];
    int npulse = 0;
    int t0;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int k = 0; k < 4; k++) begin
      {qa, qb} = seq[k];
      t0 = cyc;
      repeat (10) begin
        @(negedge clk);
        n_chk++;
        if ({inc, dec, dir, err} !== {m_inc, m_dec, m_dir, m_err}) begin
          n_fail++; $display("FAIL rev_model got=%b want=%b", {inc, dec, dir, err}, {m_inc, m_dec, m_dir, m_err});
        end
        if (dec === 1'b1) begin
          npulse++;
          n_chk++;
          if (cyc - t0 != LAT || dir !== 1'b0) begin
            n_fail++; $display("FAIL rev_latency_dir got=%0d/%b want=%0d/0", cyc - t0, dir, LAT);
          end
        end
        n_chk++;
        if (inc !== 1'b0) begin
          n_fail++; $display("FAIL rev_no_inc got=%b want=0", inc);
        end
      end
    end
    n_chk++;
    if (npulse != 4) begin
      n_fail++; $display("FAIL rev_count got=%0d want=4", npulse);
    end
  endtask

  task automatic test_glitch();
    int n_ev = 0;
    int n_inc = 0;
    int n_dec = 0;
    qa = 1; repeat (3) @(negedge clk); qa = 0;
    repeat (15) begin
      @(negedge clk);
      if (inc || dec || err) n_ev++;
    end
    n_chk++;
    if (n_ev != 0) begin
      n_fail++; $display("FAIL glitch_short got=%0d events want=0", n_ev);
    end
    qa = 1; repeat (4) @(negedge clk); qa = 0;
    repeat (20) begin
      @(negedge clk);
      n_chk++;
      if ({inc, dec, dir, err} !== {m_inc, m_dec, m_dir, m_err}) begin
        n_fail++; $display("FAIL glitch_model got=%b want=%b", {inc, dec, dir, err}, {m_inc, m_dec, m_dir, m_err});
      end
      if (inc) n_inc++;
      if (dec) n_dec++;
    end
    n_chk++;
    if (n_inc != 1 || n_dec != 1) begin
      n_fail++; $display("FAIL glitch_held got=%0d inc %0d dec want=1 inc 1 dec", n_inc, n_dec);
    end
  endtask

  task automatic test_illegal();
    int t0;
    int npulse = 0;
    qa = 1; qb = 1; t0 = cyc;
    repeat (12) begin
      @(negedge clk);
      if (inc || dec) npulse++;
      if (cyc - t0 == LAT - 1) begin
        n_chk++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_early got=%b want=0", err); end
      end
      if (cyc - t0 == LAT) begin
        n_chk++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got=%b want=1", err); end
      end
    end
    n_chk++;
    if (npulse != 0) begin n_fail++; $display("FAIL illegal_no_pulse got=%0d want=0", npulse); end
    clr_err = 1; @(negedge clk); clr_err = 0;
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL clr_err got=%b want=0", err); end
    qa = 0; t0 = cyc; npulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (inc) begin
        npulse++;
        n_chk++;
        if (cyc - t0 != LAT) begin n_fail++; $display("FAIL after_clr_latency got=%0d want=%0d", cyc - t0, LAT); end
      end
    end
    n_chk++;
    if (npulse != 1) begin n_fail++; $display("FAIL after_clr_inc got=%0d want=1", npulse); end
  endtask

  task automatic test_reset_mid();
    int t0;
    int n_ev = 0;
    int npulse = 0;
    qa = 1;
    repeat (10) @(negedge clk);
    rst = 1; @(negedge clk);
    n_chk++;
    if ({inc, dec, dir, err} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset got=%b want=0000", {inc, dec, dir, err});
    end
    rst = 0;
    repeat (12) begin
      @(negedge clk);
      if (inc || dec || err) n_ev++;
    end
    n_chk++;
    if (n_ev != 0) begin n_fail++; $display("FAIL mid_reset_settle got=%0d events want=0", n_ev); end
    qa = 0; t0 = cyc;
    repeat (10) begin
      @(negedge clk);
      if (inc) begin
        npulse++;
        n_chk++;
        if (cyc - t0 != LAT) begin n_fail++; $display("FAIL mid_reset_latency got=%0d want=%0d", cyc - t0, LAT); end
      end
    end
    n_chk++;
    if (npulse != 1) begin n_fail++; $display("FAIL mid_reset_inc got=%0d want=1", npulse); end
  endtask

  task automatic test_set_clr_same();
    int t0;
    qa = 1; qb = 0;
    repeat (10) @(negedge clk);
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL setclr_pre got=%b want=1", err); end
    qa = 0; qb = 1; t0 = cyc;
    repeat (10) begin
      @(negedge clk);
      n_chk++;
      if ({inc, dec, dir, err} !== {m_inc, m_dec, m_dir, m_err}) begin
        n_fail++; $display("FAIL setclr_model got=%b want=%b", {inc, dec, dir, err}, {m_inc, m_dec, m_dir, m_err});
      end
      clr_err = (cyc - t0 == LAT - 1);
    end
    clr_err = 0;
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL set_wins got=%b want=1", err); end
    clr_err = 1; @(negedge clk); clr_err = 0;
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL setclr_clear got=%b want=0", err); end
  endtask

  task automatic test_random();
    logic [1:0] code [4];
    logic [1:0] vq[$];
    int         nq[$];
    int         p, r;
    code = '{2'b00, 2'b10, 2'b11, 2'b01};
    for (int seg = 0; seg < 150; seg++) begin
      p = pos({qa, qb});
      r = $urandom_range(0, 31);
      vq.delete(); nq.delete();
      if (r == 0) begin
        rst = 1; @(negedge clk);
        n_chk++;
        if ({inc, dec, dir, err} !== {m_inc, m_dec, m_dir, m_err}) begin
          n_fail++; $display("FAIL rand_rst got=%b want=%b", {inc, dec, dir, err}, {m_inc, m_dec, m_dir, m_err});
        end
        rst = 0;
      end
      if (r < 20) begin
        vq.push_back(code[(p + (($urandom_range(0, 1) != 0) ? 1 : 3)) % 4]);
      end else if (r < 25) begin
        vq.push_back(code[(p + 2) % 4]);
      end else begin
        vq.push_back({qa, qb} ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01));
        nq.push_back($urandom_range(1, FL - 1));
        vq.push_back({qa, qb});
      end
      nq.push_back($urandom_range(1, 14));
      for (int i = 0; i < vq.size(); i++) begin
        {qa, qb} = vq[i];
        for (int c = 0; c < nq[i]; c++) begin
          @(negedge clk);
          n_chk++;
          if ({inc, dec, dir, err} !== {m_inc, m_dec, m_dir, m_err}) begin
            n_fail++; $display("FAIL rand_model cyc=%0d got=%b want=%b", cyc, {inc, dec, dir, err}, {m_inc, m_dec, m_dir, m_err});
          end
          n_chk++;
          if (inc && dec) begin n_fail++; $display("FAIL rand_exclusive got=11 want=not both"); end
          clr_err = ($urandom_range(0, 15) == 0);
        end
      end
    end
    clr_err = 0;
  endtask

  initial begin
    rst = 1; qa = 0; qb = 0; clr_err = 0;
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_reset_mid();
    test_set_clr_same();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Quadrature front end that converts two raw, asynchronous encoder phases (qa, qb) into single-cycle inc/dec step pulses.
- Its outputs drive the up/down counter's inc/dec inputs directly.
- Contains synchronisation, per-channel glitch filtering, a start-up settle state machine and illegal-transition detection.

Parameters:
- SYNC_STAGES, default 2: synchroniser flops per input channel (minimum 2).
- FILTER_LEN, default 4: consecutive cycles a synchronised level must differ from the filtered level before the filtered level updates (minimum 1).

Ports:
- clk      input   1  system clock
- rst      input   1  reset
- qa       input   1  raw encoder phase A, asynchronous
- qb       input   1  raw encoder phase B, asynchronous
- clr_err  input   1  one-cycle pulse, clears err
- inc      output  1  one-cycle forward step pulse
- dec      output  1  one-cycle reverse step pulse
- dir      output  1  direction of last valid step (1 = forward)
- err      output  1  sticky illegal-transition flag

Interface rules:
- Reset rst is synchronous, active-high; clock is clk. All state updates occur on posedge clk.

Behaviour:
- Reset values:
  - inc = 0, dec = 0, dir = 0, err = 0.
  - All synchroniser flops, filtered levels and filter counters = 0.
  - FSM = INIT.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel.
- Filter, per channel:
  - A counter increments while sync != filt.
  - The counter clears whenever sync == filt.
  - When sync has differed for FILTER_LEN consecutive cycles, filt takes sync and the counter clears.
- Quadrature state is cur = {filt_a, filt_b}; prev is a registered copy.
- Forward sequence (inc): 00 -> 10 -> 11 -> 01 -> 00.
- Reverse sequence (dec): the opposite order.
- No change: no pulse.
- Both bits changing in the same cycle is illegal: set err, no pulse, prev still updates to cur.
- inc and dec are registered and never both high.
- Latency from a raw edge held stable to the inc/dec pulse is exactly SYNC_STAGES + FILTER_LEN + 1 cycles (7 at defaults).
- dir updates in the same cycle as each inc (to 1) or dec (to 0). It holds otherwise, including across err.
- FSM:
  - INIT: a settle counter counts SYNC_STAGES + FILTER_LEN cycles. On terminal count, load prev = cur and go to TRACK. No inc, dec or err is produced in INIT.
  - TRACK: classify each transition as above every cycle. TRACK is left only by rst.
- err:
  - Set on an illegal transition.
  - Cleared by clr_err.
  - If set and clear occur in the same cycle, set wins.
  - clr_err during INIT clears err.
- Reset mid-operation: all state returns to reset values within the cycle rst is sampled. A non-00 encoder position after reset produces no pulse (INIT absorbs it).
- Filter glitches shorter than FILTER_LEN cycles never reach cur.

Decomposition:
- Shared package quad_pkg contains:
  - The FSM state encoding (INIT, TRACK).
  - The 2-bit phase constants.
  - A classify function: (prev, cur) -> {none, fwd, rev, illegal}.
- One natural sub-module, quad_sync_filter:
  - Contains the synchroniser plus glitch filter for one channel.
  - Parameters SYNC_STAGES and FILTER_LEN; ports clk, rst, din -> dout.
  - Instantiated twice, once per channel.

Test Plan:
- Rst, then qa=qb=0 for 20 cycles; step forward 00->10->11->01->00, 10 cycles per step -> 4 inc pulses, each 1 cycle wide, 7 cycles after each raw change; dec never high; dir=1; err=0.
- From 00, step reverse 00->01->11->10->00 -> 4 dec pulses at +7 cycles; dir=0 after the first; inc never high.
- From 00, qa high for 3 cycles then low (FILTER_LEN=4) -> no inc/dec/err. Repeat with qa held 4 cycles -> exactly one inc.
- From 00, drive qa and qb to 1 on the same clock -> err=1 at +7 cycles, no pulse. Pulse clr_err -> err=0 next cycle. Then 11->01 -> inc.
- Hold at 11, assert rst mid-stream for 1 cycle -> all outputs 0 next cycle; no pulse and no err during the following 6-cycle settle; then 11->01 -> inc at +7 cycles.
- With err=1, an illegal transition landing in the same cycle as clr_err -> err stays 1.
